// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_sched
//  Purpose  : Update scheduler for the local-history branch predictor.
//             After reset it sweeps the PHT (weakly not-taken) and the BHT
//             (zero history). Resolved M-stage branches are buffered in a
//             small FIFO and, once the sweep is done, drained one per cycle
//             as a read-modify-write on both tables.
//  Ports    : clk, rst (async, active-low)
//             branchM/pcsrcM/hashed_pcM/hashed_pc2M : resolved branch in M
//             full, init_busy, drop_cnt              : status
//             bht_raddr/bht_rdata, pht_raddr/pht_rdata : table read ports
//             bht_we/waddr/wdata, pht_we/waddr/wdata   : table write ports
//  Revision : 1.0  initial release
// ============================================================================
module bp_update_sched #(
    parameter int PHT_DEPTH  = 7,
    parameter int BHT_DEPTH  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           branchM,
    input  logic                           pcsrcM,
    input  logic [BHT_DEPTH-1:0]           hashed_pcM,
    input  logic [BHT_DEPTH-1:0]           hashed_pc2M,
    output logic                           full,
    output logic                           init_busy,
    output logic [7:0]                     drop_cnt,
    output logic [BHT_DEPTH-1:0]           bht_raddr,
    input  logic [PHT_DEPTH-BHT_DEPTH-1:0] bht_rdata,
    output logic [PHT_DEPTH-1:0]           pht_raddr,
    input  logic [1:0]                     pht_rdata,
    output logic                           bht_we,
    output logic [BHT_DEPTH-1:0]           bht_waddr,
    output logic [PHT_DEPTH-BHT_DEPTH-1:0] bht_wdata,
    output logic                           pht_we,
    output logic [PHT_DEPTH-1:0]           pht_waddr,
    output logic [1:0]                     pht_wdata
);

    localparam int H  = PHT_DEPTH - BHT_DEPTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * BHT_DEPTH + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PHT_DEPTH-1:0] c_q, c_d;
    logic [EW-1:0]        fifo_q [FIFO_DEPTH];
    logic [EW-1:0]        fifo_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic                 w_pop, w_push, w_drop;
    logic [EW-1:0]        w_head;
    logic [BHT_DEPTH-1:0] w_head_pc, w_head_pc2;
    logic                 w_head_dir;
    logic [PHT_DEPTH-1:0] w_pht_idx;
    logic [1:0]           w_pht_next;

    // Head entry layout: {hashed_pc, hashed_pc2, pcsrc}
    assign w_head     = fifo_q[rd_ptr_q];
    assign w_head_pc  = w_head[EW-1 -: BHT_DEPTH];
    assign w_head_pc2 = w_head[BHT_DEPTH:1];
    assign w_head_dir = w_head[0];
    assign w_pht_idx  = {w_head_pc2, bht_rdata};

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign init_busy = (state_q == ST_INIT);
    assign drop_cnt  = drop_cnt_q;
    assign bht_raddr = w_head_pc;
    assign pht_raddr = w_pht_idx;

    // Entries only leave the FIFO once the sweep is finished.
    assign w_pop  = (state_q == ST_RUN) && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = branchM && (!full || w_pop);
    assign w_drop = branchM && full && !w_pop;

    // 2-bit saturating counter update of the addressed PHT entry.
    always_comb begin
        w_pht_next = pht_rdata;
        if (w_head_dir) begin
            if (pht_rdata != 2'b11) w_pht_next = pht_rdata + 2'b01;
        end else begin
            if (pht_rdata != 2'b00) w_pht_next = pht_rdata - 2'b01;
        end
    end

    // Sweep / drain control and table write ports.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        bht_we    = 1'b0;
        bht_waddr = w_head_pc;
        bht_wdata = {bht_rdata[H-2:0], w_head_dir};
        pht_we    = 1'b0;
        pht_waddr = w_pht_idx;
        pht_wdata = w_pht_next;
        case (state_q)
            ST_INIT: begin
                pht_we    = 1'b1;
                pht_waddr = c_q;
                pht_wdata = 2'b01;
                // The BHT is smaller: only the first 2^BHT_DEPTH sweep steps hit it.
                bht_we    = (c_q[PHT_DEPTH-1:BHT_DEPTH] == '0);
                bht_waddr = c_q[BHT_DEPTH-1:0];
                bht_wdata = '0;
                c_d       = c_q + PHT_DEPTH'(1);
                if (c_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                bht_we = w_pop;
                pht_we = w_pop;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // FIFO bookkeeping.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = {hashed_pcM, hashed_pc2M, pcsrcM};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (w_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            c_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_update_sched
//  Purpose  : Self-checking bench for bp_update_sched. The bench owns the
//             BHT/PHT storage and keeps a reference copy of both tables that
//             it updates from the ordered list of accepted branches.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_sched;

    localparam int PD = 7;
    localparam int BD = 3;
    localparam int FD = 4;
    localparam int H  = PD - BD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          branchM = 1'b0;
    logic          pcsrcM = 1'b0;
    logic [BD-1:0] hashed_pcM = '0;
    logic [BD-1:0] hashed_pc2M = '0;
    logic          full, init_busy;
    logic [7:0]    drop_cnt;
    logic [BD-1:0] bht_raddr, bht_waddr;
    logic [H-1:0]  bht_rdata, bht_wdata;
    logic [PD-1:0] pht_raddr, pht_waddr;
    logic [1:0]    pht_rdata, pht_wdata;
    logic          bht_we, pht_we;

    logic [H-1:0]  bht_mem [2**BD];
    logic [1:0]    pht_mem [2**PD];
    logic [H-1:0]  ref_bht [2**BD];
    logic [1:0]    ref_pht [2**PD];

    int total = 0;
    int bad   = 0;

    bp_update_sched #(.PHT_DEPTH(PD), .BHT_DEPTH(BD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .branchM(branchM), .pcsrcM(pcsrcM),
        .hashed_pcM(hashed_pcM), .hashed_pc2M(hashed_pc2M),
        .full(full), .init_busy(init_busy), .drop_cnt(drop_cnt),
        .bht_raddr(bht_raddr), .bht_rdata(bht_rdata),
        .pht_raddr(pht_raddr), .pht_rdata(pht_rdata),
        .bht_we(bht_we), .bht_waddr(bht_waddr), .bht_wdata(bht_wdata),
        .pht_we(pht_we), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata)
    );

    always #5 clk = ~clk;

    // Table storage driven by the DUT write ports, combinational read.
    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
    end
    assign bht_rdata = bht_mem[bht_raddr];
    assign pht_rdata = pht_mem[pht_raddr];

    // ---------------- reference model ----------------
    task automatic model_sweep();
        for (int i = 0; i < 2**PD; i++) ref_pht[i] = 2'b01;
        for (int i = 0; i < 2**BD; i++) ref_bht[i] = '0;
    endtask

    task automatic model_apply(input logic [BD-1:0] pc, input logic [BD-1:0] pc2, input logic dir);
        logic [H-1:0]  bhr;
        logic [PD-1:0] idx;
        int            ctr;
        bhr = ref_bht[pc];
        idx = {pc2, bhr};
        ctr = int'(ref_pht[idx]);
        ctr = dir ? ((ctr < 3) ? ctr + 1 : 3) : ((ctr > 0) ? ctr - 1 : 0);
        ref_pht[idx] = 2'(ctr);
        ref_bht[pc]  = {bhr[H-2:0], dir};
    endtask

    function automatic int tables_diff();
        int n = 0;
        for (int i = 0; i < 2**PD; i++) if (pht_mem[i] !== ref_pht[i]) n++;
        for (int i = 0; i < 2**BD; i++) if (bht_mem[i] !== ref_bht[i]) n++;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Leaves the bench at the negedge of "cycle 0" (before the first edge).
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        branchM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic finish_sweep();
        int k = 0;
        while (init_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (init_busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_timeout init_busy=%0b want 0", init_busy);
        end
        model_sweep();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({init_busy, full, drop_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_status busy/full/drop=%b/%b/%0d want 1/0/0", init_busy, full, drop_cnt);
        end
        total++;
        if ({pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata} !==
            {1'b1, 7'd0, 2'b01, 1'b1, 3'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_writes pht=%b/%h/%b bht=%b/%h/%h want 1/00/01 1/0/0",
                     pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata);
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2**PD; i++) begin
            logic exp_bwe;
            exp_bwe = (i < 2**BD);
            total++;
            if ({init_busy, pht_we, pht_waddr, pht_wdata, bht_we} !== {1'b1, 1'b1, 7'(i), 2'b01, exp_bwe}) begin
                bad++;
                $display("FAIL sweep_c%0d busy=%b pht=%b/%h/%b bht_we=%b want 1 1/%h/01 %b",
                         i, init_busy, pht_we, pht_waddr, pht_wdata, bht_we, 7'(i), exp_bwe);
            end
            if (exp_bwe) begin
                total++;
                if ({bht_waddr, bht_wdata} !== {3'(i), 4'd0}) begin
                    bad++;
                    $display("FAIL sweep_bht_c%0d addr/data=%h/%h want %h/0", i, bht_waddr, bht_wdata, 3'(i));
                end
            end
            @(negedge clk);
        end
        total++;
        if ({init_busy, pht_we, bht_we} !== 3'b000) begin
            bad++;
            $display("FAIL sweep_end busy/pht_we/bht_we=%b%b%b want 000", init_busy, pht_we, bht_we);
        end
        model_sweep();
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL sweep_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    task automatic test_single();
        branchM = 1'b1; pcsrcM = 1'b1; hashed_pcM = 3'd5; hashed_pc2M = 3'd2;
        @(negedge clk);
        branchM = 1'b0;
        total++;
        if ({pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata} !==
            {1'b1, 7'h20, 2'b10, 1'b1, 3'd5, 4'b0001}) begin
            bad++;
            $display("FAIL single_update pht=%b/%h/%b bht=%b/%h/%b want 1/20/10 1/5/0001",
                     pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata);
        end
        model_apply(3'd5, 3'd2, 1'b1);
        @(negedge clk);
        total++;
        if ({pht_we, bht_we} !== 2'b00) begin
            bad++;
            $display("FAIL single_idle we=%b%b want 00", pht_we, bht_we);
        end
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL single_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    task automatic test_back_to_back();
        logic [PD-1:0] exp_idx [4] = '{7'h20, 7'h21, 7'h23, 7'h27};
        do_reset();
        finish_sweep();
        for (int j = 0; j < 4; j++) begin
            branchM = 1'b1; pcsrcM = 1'b1; hashed_pcM = 3'd5; hashed_pc2M = 3'd2;
            @(negedge clk);
            total++;
            if ({pht_we, pht_waddr, pht_wdata, bht_we} !== {1'b1, exp_idx[j], 2'b10, 1'b1}) begin
                bad++;
                $display("FAIL b2b_%0d pht=%b/%h/%b bht_we=%b want 1/%h/10 1",
                         j, pht_we, pht_waddr, pht_wdata, bht_we, exp_idx[j]);
            end
            model_apply(3'd5, 3'd2, 1'b1);
        end
        branchM = 1'b0;
        @(negedge clk);
        total++;
        if ({pht_we, bht_mem[5]} !== {1'b0, 4'hF}) begin
            bad++;
            $display("FAIL b2b_final pht_we=%b bht5=%h want 0/f", pht_we, bht_mem[5]);
        end
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL b2b_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    task automatic test_init_overflow();
        logic [BD-1:0] e_pc [5];
        logic [BD-1:0] e_pc2 [5];
        logic          e_dir [5];
        int            base;
        base = int'($urandom_range(0, 7));
        do_reset();
        repeat (10) @(negedge clk);          // cycle 10
        for (int n = 0; n < 6; n++) begin
            branchM     = 1'b1;
            hashed_pcM  = 3'((base + n) % 8);
            hashed_pc2M = 3'($urandom);
            pcsrcM      = 1'($urandom);
            if (n < 4) begin
                e_pc[n] = hashed_pcM; e_pc2[n] = hashed_pc2M; e_dir[n] = pcsrcM;
            end
            @(negedge clk);
            total++;
            if ({full, drop_cnt} !== {(n >= 3), 8'((n >= 4) ? n - 3 : 0)}) begin
                bad++;
                $display("FAIL ovf_push%0d full/drop=%b/%0d want %b/%0d",
                         n, full, drop_cnt, (n >= 3), (n >= 4) ? n - 3 : 0);
            end
        end
        branchM = 1'b0;                      // cycle 16
        repeat (111) @(negedge clk);         // cycle 127
        total++;
        if ({init_busy, pht_we, pht_waddr} !== {1'b1, 1'b1, 7'd127}) begin
            bad++;
            $display("FAIL ovf_last_sweep busy/we/addr=%b/%b/%h want 1/1/7f", init_busy, pht_we, pht_waddr);
        end
        @(negedge clk);                      // cycle 128: RUN, FIFO full
        model_sweep();
        for (int p = 0; p < 5; p++) begin
            if (p == 0) begin
                branchM     = 1'b1;
                hashed_pcM  = 3'($urandom);
                hashed_pc2M = 3'($urandom);
                pcsrcM      = 1'($urandom);
                e_pc[4] = hashed_pcM; e_pc2[4] = hashed_pc2M; e_dir[4] = pcsrcM;
            end
            if (p == 1) begin
                total++;
                if ({full, drop_cnt} !== {1'b1, 8'd2}) begin
                    bad++;
                    $display("FAIL ovf_pushpop full/drop=%b/%0d want 1/2", full, drop_cnt);
                end
            end
            total++;
            if ({init_busy, pht_we, bht_we, bht_waddr} !== {1'b0, 1'b1, 1'b1, e_pc[p]}) begin
                bad++;
                $display("FAIL ovf_pop%0d busy/we/we/addr=%b/%b/%b/%h want 0/1/1/%h",
                         p, init_busy, pht_we, bht_we, bht_waddr, e_pc[p]);
            end
            model_apply(e_pc[p], e_pc2[p], e_dir[p]);
            @(negedge clk);
            branchM = 1'b0;
        end
        total++;
        if ({pht_we, bht_we, full} !== 3'b000) begin
            bad++;
            $display("FAIL ovf_drained we/we/full=%b%b%b want 000", pht_we, bht_we, full);
        end
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL ovf_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    task automatic test_random_run();
        int saw_full = 0;
        for (int i = 0; i < 300; i++) begin
            branchM     = 1'($urandom);
            hashed_pcM  = 3'($urandom);
            hashed_pc2M = 3'($urandom);
            pcsrcM      = 1'($urandom);
            if (branchM) model_apply(hashed_pcM, hashed_pc2M, pcsrcM);
            @(negedge clk);
            if (full !== 1'b0) saw_full++;
        end
        branchM = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (saw_full !== 0) begin
            bad++;
            $display("FAIL rand_full cycles_full=%0d want 0", saw_full);
        end
        total++;
        if (drop_cnt !== 8'd2) begin
            bad++;
            $display("FAIL rand_drop drop_cnt=%0d want 2", drop_cnt);
        end
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL rand_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            branchM = 1'b1; hashed_pcM = 3'($urandom); hashed_pc2M = 3'($urandom); pcsrcM = 1'b1;
            @(negedge clk);
        end
        branchM = 1'b0;                      // cycle 10: full, one drop
        repeat (40) @(negedge clk);          // cycle 50
        total++;
        if ({full, drop_cnt, pht_waddr} !== {1'b1, 8'd1, 7'd50}) begin
            bad++;
            $display("FAIL mid_pre full/drop/c=%b/%0d/%0d want 1/1/50", full, drop_cnt, pht_waddr);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({init_busy, full, drop_cnt, pht_waddr} !== {1'b1, 1'b0, 8'd0, 7'd0}) begin
            bad++;
            $display("FAIL mid_async busy/full/drop/c=%b/%b/%0d/%0d want 1/0/0/0",
                     init_busy, full, drop_cnt, pht_waddr);
        end
        @(negedge clk);
        rst = 1'b1;                          // cycle 0 again
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({pht_we, pht_waddr} !== {1'b1, 7'(i)}) begin
                bad++;
                $display("FAIL mid_restart_c%0d we/addr=%b/%h want 1/%h", i, pht_we, pht_waddr, 7'(i));
            end
            @(negedge clk);
        end
        finish_sweep();
        total++;
        if ({pht_we, bht_we, full} !== 3'b000) begin
            bad++;
            $display("FAIL mid_fifo_lost we/we/full=%b%b%b want 000", pht_we, bht_we, full);
        end
        total++;
        if (tables_diff() !== 0) begin
            bad++;
            $display("FAIL mid_tables diff_entries=%0d want 0", tables_diff());
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single();
        test_back_to_back();
        test_init_overflow();
        test_random_run();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bp_update_sched.md
# bp_update_sched

Update scheduler for the local-history branch predictor tables. It buffers resolved-branch outcomes from the M stage in a small FIFO and performs the initial table sweep after reset. It then drains the FIFO one update per cycle as a read-modify-write on the BHT and PHT through single write ports. It sits between the M-stage branch resolution logic and the predictor's table storage, and owns every write to both tables.

## Interface
- PHT_DEPTH, 7: log2 of PHT entries.
- BHT_DEPTH, 3: log2 of BHT entries; history width H = PHT_DEPTH-BHT_DEPTH.
- FIFO_DEPTH, 4: update FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- branchM  in  1  a resolved branch is present in M this cycle.
- pcsrcM  in  1  resolved direction (1 = taken).
- hashed_pcM  in  BHT_DEPTH  BHT index of the resolved branch.
- hashed_pc2M  in  BHT_DEPTH  PHT high-index bits of the resolved branch.
- full  out  1  FIFO full; the pipeline must hold M while high.
- init_busy  out  1  table sweep in progress.
- drop_cnt  out  8  saturating count of dropped updates.
- bht_raddr  out  BHT_DEPTH  BHT read index (head entry).
- bht_rdata  in  H  BHT entry at bht_raddr, combinational.
- pht_raddr  out  PHT_DEPTH  PHT read index.
- pht_rdata  in  2  PHT entry at pht_raddr, combinational.
- bht_we / bht_waddr / bht_wdata  out  1 / BHT_DEPTH / H  BHT write port.
- pht_we / pht_waddr / pht_wdata  out  1 / PHT_DEPTH / 2  PHT write port.

## Operation
- FSM states:
  - INIT: entered on reset.
    - A sweep counter c runs 0..2^PHT_DEPTH-1, one step per cycle.
    - Each cycle: pht_we=1, pht_waddr=c, pht_wdata=2'b01.
    - bht_we=1 only while c < 2^BHT_DEPTH, with bht_waddr=c[BHT_DEPTH-1:0] and bht_wdata=0.
    - After writing c = 2^PHT_DEPTH-1, the FSM goes to RUN.
  - RUN: terminal; left only by reset.
- FIFO entry = {hashed_pcM, hashed_pc2M, pcsrcM}.
- Push when branchM=1 and the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - Pushes are accepted during INIT too; entries wait there until RUN.
- branchM=1 while full and with no pop: the entry is discarded and drop_cnt increments, saturating at 255.
- Pop: in RUN with the FIFO non-empty, exactly one entry per cycle.
  - bht_raddr = head.hashed_pc; BHR = bht_rdata.
  - Index = {head.hashed_pc2, BHR}, driven on pht_raddr and pht_waddr.
  - bht_we=1, bht_wdata={BHR[H-2:0], head.pcsrc}.
  - pht_we=1, pht_wdata = 2-bit saturating counter applied to pht_rdata: +1 if taken (max 3), −1 if not taken (min 0).
- Write enables are 0 in RUN when the FIFO is empty. Addresses and data are don't-care when the enables are low.
- full = (count == FIFO_DEPTH). count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - Outputs: init_busy=1, full=0, drop_cnt=0, count=0, and both pointers 0.
  - Write ports: pht_we=1 and bht_we=1 at c=0 (INIT writes begin immediately after reset deassert).
- The sweep takes exactly 2^PHT_DEPTH cycles after reset deassert. init_busy drops in the cycle after the last sweep write.
- Push latency: an entry pushed at edge k into an empty FIFO in RUN has its writes asserted in cycle k..k+1. The tables commit at edge k+1.
- Back-to-back updates to the same hashed_pc read the value committed at the previous edge. No forwarding is needed because writes complete before the next read.
- Simultaneous push and pop when full: both occur; full stays 1 and count is unchanged.
- Reset asserted mid-sweep or mid-drain: all state returns to reset values asynchronously and the sweep restarts from c=0. Buffered entries are lost.
- All outputs are derived from registers plus the combinational table read data. There is no combinational path from branchM to any write port.

## Test plan
- Reset release, no branches -> 128 cycles with pht_we=1 and pht_wdata=01; bht_we=1 for exactly the first 8 cycles; init_busy falls at cycle 128.
- 3 branches pushed during INIT -> no RUN writes until cycle 128, then 3 consecutive pops in FIFO order.
- Single taken branch, hashed_pcM=5, hashed_pc2M=2, BHT[5]=0, PHT[0x20]=01 -> next cycle pht_waddr=0x20, pht_wdata=10, bht_wdata=0001.
- Same pc taken 4× back-to-back -> PHT indices 0x20, 0x21, 0x23, 0x27, each written 01→10; BHT[5] ends at 1111.
- 6 branches in 6 cycles during INIT with FIFO_DEPTH=4 -> full=1 after the 4th, drop_cnt=2, and only the first 4 are applied.
- Reset pulsed at sweep cycle 50 -> sweep restarts at c=0 and the FIFO is empty.
